// File: rtl/lockin_cuadratura_multicanal.sv
// Square-wave quadrature lock-in for NUM_CH time-interleaved channels.
// Per-channel I/Q accumulate-and-dump over F reference cycles of P samples each.
module lockin_cuadratura_multicanal #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int CH_BITS     = 2,
    parameter int ACC_WIDTH   = 64,
    parameter int PTOS_BITS   = 16,
    parameter int FRAMES_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable_gral,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    input  logic [PTOS_BITS-1:0]   ptos_x_ciclo,
    input  logic [FRAMES_BITS-1:0] frames_integracion,
    input  logic                   one_shot,
    output logic [ACC_WIDTH-1:0]   data_out_i,
    output logic [ACC_WIDTH-1:0]   data_out_q,
    output logic [CH_BITS-1:0]     data_out_channel,
    output logic                   data_out_valid,
    output logic                   ready_to_calculate,
    output logic                   processing_finished
);
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

    logic [PTOS_BITS-1:0]   p_q, p_d, n_q, n_d, p_masked;
    logic [FRAMES_BITS-1:0] f_q, f_d, fr_q, fr_d;
    logic [CH_BITS-1:0]     ch_q, ch_d, out_ch_q, out_ch_d;
    logic [ACC_WIDTH-1:0]   out_i_q, out_i_d, out_q_q, out_q_d;
    logic                   valid_q, valid_d, ready_q, ready_d, fin_q, fin_d;

    logic                   accept, last_ch, last_n, last_fr, dump;
    logic                   sin_neg, cos_neg;
    logic [ACC_WIDTH-1:0]   x_ext, sum_i, sum_q;
    logic [ACC_WIDTH-1:0]   acc_i_all [NUM_CH];
    logic [ACC_WIDTH-1:0]   acc_q_all [NUM_CH];

    // Config sanitising: P is forced to a multiple of 4 (>=4), F to >=1.
    always_comb begin
        p_masked = ptos_x_ciclo & ~PTOS_BITS'(3);
        p_d      = (p_masked == '0) ? PTOS_BITS'(4) : p_masked;
        f_d      = (frames_integracion == '0) ? FRAMES_BITS'(1) : frames_integracion;
    end

    always_comb begin
        accept  = enable_gral & data_in_valid & ~fin_q;
        last_ch = (ch_q == LAST_CH);
        last_n  = (n_q == p_q - PTOS_BITS'(1));
        last_fr = (fr_q == f_q - FRAMES_BITS'(1));
        dump    = accept & last_n & last_fr;
        sin_neg = (n_q >= (p_q >> 1));
        cos_neg = (n_q >= (p_q >> 2)) && (n_q < (p_q >> 1) + (p_q >> 2));
        x_ext   = {{(ACC_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
        sum_i   = sin_neg ? acc_i_all[ch_q] - x_ext : acc_i_all[ch_q] + x_ext;
        sum_q   = cos_neg ? acc_q_all[ch_q] - x_ext : acc_q_all[ch_q] + x_ext;

        ch_d = ch_q;
        n_d  = n_q;
        fr_d = fr_q;
        if (accept) begin
            ch_d = last_ch ? '0 : ch_q + CH_BITS'(1);
            if (last_ch) begin
                n_d = last_n ? '0 : n_q + PTOS_BITS'(1);
                if (last_n) begin
                    fr_d = last_fr ? '0 : fr_q + FRAMES_BITS'(1);
                end
            end
        end

        valid_d  = dump;
        out_i_d  = dump ? sum_i : out_i_q;
        out_q_d  = dump ? sum_q : out_q_q;
        out_ch_d = dump ? ch_q  : out_ch_q;
        ready_d  = ready_q | (dump & last_ch);
        fin_d    = fin_q | (dump & last_ch & one_shot);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_q      <= p_d;
            f_q      <= f_d;
            ch_q     <= '0;
            n_q      <= '0;
            fr_q     <= '0;
            out_i_q  <= '0;
            out_q_q  <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            ch_q     <= ch_d;
            n_q      <= n_d;
            fr_q     <= fr_d;
            out_i_q  <= out_i_d;
            out_q_q  <= out_q_d;
            out_ch_q <= out_ch_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            fin_q    <= fin_d;
        end
    end

    // One accumulator pair per channel; the dump sample reloads it with zero.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [ACC_WIDTH-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;

        always_comb begin
            acc_i_d = acc_i_q;
            acc_q_d = acc_q_q;
            if (accept && (ch_q == CH_BITS'(gi))) begin
                acc_i_d = dump ? '0 : sum_i;
                acc_q_d = dump ? '0 : sum_q;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else begin
                acc_i_q <= acc_i_d;
                acc_q_q <= acc_q_d;
            end
        end

        assign acc_i_all[gi] = acc_i_q;
        assign acc_q_all[gi] = acc_q_q;
    end

    assign data_out_i          = out_i_q;
    assign data_out_q          = out_q_q;
    assign data_out_channel    = out_ch_q;
    assign data_out_valid      = valid_q;
    assign ready_to_calculate  = ready_q;
    assign processing_finished = fin_q;
endmodule

// File: tb/tb_lockin_cuadratura_multicanal.sv
// Bench for the multichannel quadrature lock-in: directed and random sample
// streams checked cycle by cycle against a sample-count based reference model.
module tb_lockin_cuadratura_multicanal;
    localparam int NCH = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable_gral = 1'b0;
    logic [31:0]        data_in = '0;
    logic               data_in_valid = 1'b0;
    logic [15:0]        ptos_x_ciclo = 16'd8;
    logic [15:0]        frames_integracion = 16'd2;
    logic               one_shot = 1'b0;
    logic [63:0]        data_out_i, data_out_q;
    logic [0:0]         data_out_channel;
    logic               data_out_valid, ready_to_calculate, processing_finished;

    lockin_cuadratura_multicanal #(
        .DATA_WIDTH(32), .NUM_CH(NCH), .CH_BITS(1), .ACC_WIDTH(64),
        .PTOS_BITS(16), .FRAMES_BITS(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable_gral(enable_gral),
        .data_in(data_in), .data_in_valid(data_in_valid),
        .ptos_x_ciclo(ptos_x_ciclo), .frames_integracion(frames_integracion),
        .one_shot(one_shot), .data_out_i(data_out_i), .data_out_q(data_out_q),
        .data_out_channel(data_out_channel), .data_out_valid(data_out_valid),
        .ready_to_calculate(ready_to_calculate),
        .processing_finished(processing_finished)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: everything derives from the accepted-sample count.
    int     m_p, m_f, m_k;
    bit     m_os, m_ready, m_fin;
    longint m_acc_i [NCH];
    longint m_acc_q [NCH];
    longint e_i, e_q;
    int     e_ch;
    longint cap_i [NCH];
    longint cap_q [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic do_reset(input int ptos, input int frames, input bit os, input int cycles);
        reset_n = 1'b0;
        data_in_valid = 1'b0;
        enable_gral = 1'b0;
        ptos_x_ciclo = 16'(ptos);
        frames_integracion = 16'(frames);
        one_shot = os;
        m_p = ptos & ~3;
        if (m_p < 4) m_p = 4;
        m_f = (frames == 0) ? 1 : frames;
        m_os = os; m_k = 0; m_ready = 0; m_fin = 0;
        e_i = 0; e_q = 0; e_ch = 0;
        for (int c = 0; c < NCH; c++) begin
            m_acc_i[c] = 0; m_acc_q[c] = 0; cap_i[c] = 12345; cap_q[c] = 12345;
        end
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_valid", 64'(data_out_valid), 64'd0);
        chk("rst_out_i", data_out_i, 64'd0);
        chk("rst_ready", 64'(ready_to_calculate), 64'd0);
        chk("rst_fin", 64'(processing_finished), 64'd0);
        reset_n = 1'b1;
    endtask

    task automatic step(input bit en, input bit vld, input int x);
        bit     exp_valid;
        int     ch, n, fr;
        longint xs;
        enable_gral = en;
        data_in_valid = vld;
        data_in = 32'(x);
        exp_valid = 0;
        if (en && vld && !m_fin) begin
            ch = m_k % NCH;
            n  = (m_k / NCH) % m_p;
            fr = (m_k / (NCH * m_p)) % m_f;
            xs = longint'(x);
            m_acc_i[ch] += (n < m_p / 2) ? xs : -xs;
            m_acc_q[ch] += (n < m_p / 4 || n >= 3 * m_p / 4) ? xs : -xs;
            m_k++;
            if (n == m_p - 1 && fr == m_f - 1) begin
                exp_valid = 1;
                e_i = m_acc_i[ch]; e_q = m_acc_q[ch]; e_ch = ch;
                m_acc_i[ch] = 0; m_acc_q[ch] = 0;
                if (ch == NCH - 1) begin
                    m_ready = 1;
                    if (m_os) m_fin = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 64'(data_out_valid), 64'(exp_valid));
        chk("out_i", data_out_i, e_i);
        chk("out_q", data_out_q, e_q);
        chk("out_ch", 64'(data_out_channel), 64'(e_ch));
        chk("ready", 64'(ready_to_calculate), 64'(m_ready));
        chk("finished", 64'(processing_finished), 64'(m_fin));
        if (data_out_valid === 1'b1) begin
            cap_i[data_out_channel] = longint'(data_out_i);
            cap_q[data_out_channel] = longint'(data_out_q);
        end
    endtask

    function automatic int gen(input int pat, input int kk);
        int ch, n;
        ch = kk % NCH;
        n  = (kk / NCH) % m_p;
        case (pat)
            0: return (ch == 0) ? ((n < 4) ? 100 : -100) : 100;
            1: return (ch == 0) ? ((n < 2 || n >= 6) ? 100 : -100) : 100;
            3: return (ch == 0) ? ((n < 2) ? 50 : -50) : int'($urandom_range(0, 1000)) - 500;
            default: return int'($urandom);
        endcase
    endfunction

    // Feeds samples until `count` more have been accepted, inserting random valid gaps.
    task automatic run(input int pat, input int count, input int gap_pct);
        int target;
        target = m_k + count;
        while (m_k < target) begin
            if (int'($urandom_range(0, 99)) < gap_pct) step(1'b1, 1'b0, int'($urandom));
            else step(1'b1, 1'b1, gen(pat, m_k));
        end
    endtask

    initial begin
        // Test 1: P=8, F=2, two blocks.
        do_reset(8, 2, 0, 3);
        run(0, 64, 0);
        chk("t1_ch0_i", 64'(cap_i[0]), 64'd1600);
        chk("t1_ch0_q", 64'(cap_q[0]), 64'd0);
        chk("t1_ch1_i", 64'(cap_i[1]), 64'd0);
        chk("t1_ch1_q", 64'(cap_q[1]), 64'd0);

        // Test 2: cosine-aligned input, two consecutive blocks.
        do_reset(8, 2, 0, 2);
        run(1, 32, 0);
        chk("t2_blk1_q", 64'(cap_q[0]), 64'd1600);
        cap_q[0] = 12345;
        run(1, 32, 0);
        chk("t2_blk2_i", 64'(cap_i[0]), 64'd0);
        chk("t2_blk2_q", 64'(cap_q[0]), 64'd1600);

        // Test 3: test 1 stimulus with valid gaps and an enable pause.
        do_reset(8, 2, 0, 2);
        run(0, 12, 30);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 7777);
        run(0, 20, 30);
        chk("t3_ch0_i", 64'(cap_i[0]), 64'd1600);
        chk("t3_ch1_q", 64'(cap_q[1]), 64'd0);

        // Test 4: one-shot, further samples ignored.
        do_reset(8, 1, 1, 2);
        run(0, 16, 0);
        chk("t4_fin", 64'(processing_finished), 64'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, int'($urandom));

        // Test 5: sanitised config P=4, F=1.
        do_reset(6, 0, 0, 2);
        run(3, 16, 20);
        chk("t5_ch0_i", 64'(cap_i[0]), 64'd200);
        chk("t5_ch0_q", 64'(cap_q[0]), 64'd0);

        // Test 6: one-cycle reset mid-block, then test 1 again.
        do_reset(8, 2, 0, 2);
        run(0, 10, 0);
        do_reset(8, 2, 0, 1);
        run(0, 32, 0);
        chk("t6_ch0_i", 64'(cap_i[0]), 64'd1600);
        chk("t6_ch1_i", 64'(cap_i[1]), 64'd0);

        // Randomized full-range data, P=12, F=3, with gaps.
        do_reset(13, 3, 0, 2);
        run(2, 216, 25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
